ldst_unit: RTL and testbench

- Memory-stage load/store engine. Consumes the decoded LdStCtrl/MemWrite/MemToReg controls produced by instruction decode for the instruction in EX/MEM.
- Issues one word-aligned request per instruction to data memory over a valid/ready handshake. Steers store bytes onto lanes, and extracts and extends load data.
- Stalls the pipeline until the access completes; flags misaligned accesses and response timeouts.

---
 rtl/ldst_pkg.sv | 33 +++
 rtl/ldst_align.sv | 67 ++++++
 rtl/ldst_unit.sv | 152 +++++++++++++++
 tb/tb_ldst_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_pkg.sv
// Shared definitions for the memory-stage load/store engine: the LdStCtrl
// encoding produced by decode, the FSM state encoding and byte-enable patterns.
package ldst_pkg;

    // LdStCtrl encoding, identical to the decoder that produces it
    localparam logic [2:0] LDST_LB  = 3'b000;
    localparam logic [2:0] LDST_LH  = 3'b001;
    localparam logic [2:0] LDST_LW  = 3'b010;
    localparam logic [2:0] LDST_LBU = 3'b011;
    localparam logic [2:0] LDST_LHU = 3'b100;
    localparam logic [2:0] LDST_SB  = 3'b101;
    localparam logic [2:0] LDST_SH  = 3'b110;
    localparam logic [2:0] LDST_SW  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ldst_state_e;

    // Byte enables, bit 3 covers bits 31:24 (big-endian byte 0)
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;

    function automatic logic is_store(input logic [2:0] ctrl);
        return (ctrl == LDST_SB) || (ctrl == LDST_SH) || (ctrl == LDST_SW);
    endfunction

endpackage

// File: rtl/ldst_align.sv
// Combinational lane logic: store byte steering, load lane extraction with
// sign/zero extension, and the alignment check for halfword/word accesses.
module ldst_align
    import ldst_pkg::*;
(
    input  logic [2:0]  st_ctrl_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_we_o,
    output logic [31:0] st_wdata_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_ctrl_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Steer store data onto byte lanes; loads carry no write enables
    always_comb begin
        st_we_o    = BE_NONE;
        st_wdata_o = st_data_i;
        case (st_ctrl_i)
            LDST_SB: begin
                st_we_o    = BE_BYTE0 >> st_addr_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            LDST_SH: begin
                st_we_o    = st_addr_lo_i[1] ? BE_HALF_LO : BE_HALF_HI;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            LDST_SW: st_we_o = BE_ALL;
            default: ;
        endcase
    end

    // Halfwords need an even address, words a multiple of four
    always_comb begin
        misalign_o = 1'b0;
        case (st_ctrl_i)
            LDST_LH, LDST_LHU, LDST_SH: misalign_o = st_addr_lo_i[0];
            LDST_LW, LDST_SW:           misalign_o = |st_addr_lo_i;
            default:                    misalign_o = 1'b0;
        endcase
    end

    // Pick the addressed lane (big-endian) and extend to 32 bits
    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    ld_byte = ld_rdata_i[31:24];
            2'd1:    ld_byte = ld_rdata_i[23:16];
            2'd2:    ld_byte = ld_rdata_i[15:8];
            default: ld_byte = ld_rdata_i[7:0];
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_rdata_i[15:0] : ld_rdata_i[31:16];
        case (ld_ctrl_i)
            LDST_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LDST_LBU: ld_data_o = {24'd0, ld_byte};
            LDST_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            LDST_LHU: ld_data_o = {16'd0, ld_half};
            default:  ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/ldst_unit.sv
// Memory-stage load/store engine: captures one memory instruction, issues a
// word-aligned valid/ready request, waits for load data under a watchdog and
// holds the pipeline until a one-cycle DONE state reports the outcome.
module ldst_unit
    import ldst_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  ldst_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    ldst_state_e      state_q;
    logic [2:0]       ctrl_q;
    logic [31:0]      addr_q;
    logic [4:0]       rd_q;
    logic             req_valid_q;
    logic [3:0]       we_q;
    logic [31:0]      wdata_q;
    logic             ld_valid_q;
    logic [31:0]      ld_data_q;
    logic [4:0]       ld_rd_q;
    logic             misalign_q;
    logic             bus_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic        st_misalign;
    logic [31:0] ld_ext;

    // Store lanes and misalignment come from the incoming instruction;
    // load extraction uses the captured ctrl/address against returned data.
    ldst_align u_align (
        .st_ctrl_i    (ldst_ctrl),
        .st_addr_lo_i (addr[1:0]),
        .st_data_i    (store_data),
        .st_we_o      (st_we),
        .st_wdata_o   (st_wdata),
        .misalign_o   (st_misalign),
        .ld_ctrl_i    (ctrl_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_rdata_i   (dmem_rdata),
        .ld_data_o    (ld_ext)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    // FSM with registered request and result outputs; result flags pulse in DONE only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= LDST_LB;
            addr_q      <= '0;
            rd_q        <= '0;
            req_valid_q <= 1'b0;
            we_q        <= BE_NONE;
            wdata_q     <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_rd_q     <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        ctrl_q <= ldst_ctrl;
                        addr_q <= addr;
                        rd_q   <= rd_in;
                        if (st_misalign) begin
                            misalign_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            we_q        <= st_we;
                            wdata_q     <= st_wdata;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        we_q        <= BE_NONE;
                        if (is_store(ctrl_q)) begin
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp_valid) begin
                        ld_data_q  <= ld_ext;
                        ld_rd_q    <= rd_q;
                        ld_valid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_C)) begin
                            bus_err_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall = ((state_q == ST_IDLE) && req_valid) ||
                   (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = {addr_q[31:2], 2'b00};
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign ld_valid       = ld_valid_q;
    assign ld_data        = ld_data_q;
    assign ld_rd          = ld_rd_q;
    assign misalign_err   = misalign_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: a small memory model answers requests; expected
// outcomes are queued when an instruction is driven and compared at DONE.
module tb_ldst_unit;
    import ldst_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  ldst_ctrl = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_in = '0;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        misalign_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        lv;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Observations gathered by drive_op
    int          obs_stall;
    bit          obs_req_seen;
    bit          obs_stable;
    logic [31:0] obs_addr;
    logic [3:0]  obs_we;
    logic [31:0] obs_wdata;
    logic        obs_lv;
    logic [31:0] obs_data;
    logic [4:0]  obs_rd;
    logic        obs_mis;
    logic        obs_berr;

    ldst_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .ldst_ctrl       (ldst_ctrl),
        .addr            (addr),
        .store_data      (store_data),
        .rd_in           (rd_in),
        .stall           (stall),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_addr       (dmem_addr),
        .dmem_we         (dmem_we),
        .dmem_wdata      (dmem_wdata),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_rdata      (dmem_rdata),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_rd           (ld_rd),
        .misalign_err    (misalign_err),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    // Drive one instruction starting just after a rising edge with the DUT in IDLE.
    // Memory raises ready after ready_delay ISSUE cycles; the response comes
    // resp_delay cycles after acceptance (never if negative). Returns after DONE.
    task automatic drive_op(input logic [2:0] ctrl, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] rd,
                            input int ready_delay, input int resp_delay,
                            input logic [31:0] rdata);
        int issue_cnt = 0;
        int since = 0;
        bit accepted = 0;
        bit done = 0;
        obs_stall = 0; obs_req_seen = 0; obs_stable = 1;
        obs_lv = 0; obs_data = '0; obs_rd = '0; obs_mis = 0; obs_berr = 0;
        obs_addr = '0; obs_we = '0; obs_wdata = '0;
        req_valid = 1'b1; ldst_ctrl = ctrl; addr = a; store_data = d; rd_in = rd;
        dmem_rdata = rdata;
        for (int c = 0; c < 64 && !done; c++) begin
            dmem_req_ready  = dmem_req_valid && (issue_cnt >= ready_delay);
            dmem_resp_valid = accepted && (resp_delay >= 0) && (since == resp_delay);
            @(negedge clk);
            if (!stall) begin
                done = 1;
                obs_lv = ld_valid; obs_data = ld_data; obs_rd = ld_rd;
                obs_mis = misalign_err; obs_berr = bus_err;
            end else begin
                obs_stall++;
            end
            if (dmem_req_valid) begin
                if (!obs_req_seen) begin
                    obs_addr = dmem_addr; obs_we = dmem_we; obs_wdata = dmem_wdata;
                end else if (dmem_addr !== obs_addr || dmem_we !== obs_we ||
                             dmem_wdata !== obs_wdata) begin
                    obs_stable = 0;
                end
                obs_req_seen = 1;
            end
            if (accepted) since++;
            if (dmem_req_valid && dmem_req_ready) begin
                accepted = 1;
                since = 1;
            end else if (dmem_req_valid) begin
                issue_cnt++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_completion: stall never dropped within 64 cycles (ctrl=%0d addr=%h)", ctrl, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, dmem_req_valid, dmem_we, ld_valid, ld_data, ld_rd, misalign_err, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: stall=%b req=%b we=%b lv=%b data=%h rd=%0d mis=%b berr=%b, want all zero",
                     stall, dmem_req_valid, dmem_we, ld_valid, ld_data, ld_rd, misalign_err, bus_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_byte();
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_SB, 32'h0000_1003, 32'h0000_00AB, 5'd0, 0, 0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr}) begin
            errors++;
            $display("FAIL sb_flags: lv/mis/berr=%b%b%b, want %b%b%b", obs_lv, obs_mis, obs_berr, e.lv, e.mis, e.berr);
        end
        checks++;
        if (obs_stall !== 2) begin
            errors++;
            $display("FAIL sb_stall_cycles: got %0d, want 2", obs_stall);
        end
        checks++;
        if (!obs_req_seen || obs_addr !== 32'h0000_1000 || obs_we !== 4'b0001 || obs_wdata !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_request: seen=%b addr=%h we=%b wdata=%h, want 1 00001000 0001 abababab",
                     obs_req_seen, obs_addr, obs_we, obs_wdata);
        end
    endtask

    task automatic test_load_byte();
        sb.push_back('{lv: 1'b1, data: 32'hFFFF_FF80, rd: 5'd5, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LB, 32'h0000_2001, 32'h0, 5'd5, 0, 1, 32'h1180_FF22);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd || obs_mis !== e.mis || obs_berr !== e.berr) begin
            errors++;
            $display("FAIL lb_result: lv=%b data=%h rd=%0d, want %b %h %0d", obs_lv, obs_data, obs_rd, e.lv, e.data, e.rd);
        end
        checks++;
        if (obs_stall !== 3 || obs_we !== 4'b0000 || obs_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL lb_latency_req: stall=%0d we=%b addr=%h, want 3 0000 00002000", obs_stall, obs_we, obs_addr);
        end
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_pulse_width: ld_valid=%b one cycle after DONE, want 0", ld_valid);
        end
        @(posedge clk); #1;
        sb.push_back('{lv: 1'b1, data: 32'h0000_0080, rd: 5'd6, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LBU, 32'h0000_2001, 32'h0, 5'd6, 0, 1, 32'h1180_FF22);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd) begin
            errors++;
            $display("FAIL lbu_result: lv=%b data=%h rd=%0d, want %b %h %0d", obs_lv, obs_data, obs_rd, e.lv, e.data, e.rd);
        end
    endtask

    task automatic test_load_half();
        sb.push_back('{lv: 1'b1, data: 32'hFFFF_F00D, rd: 5'd10, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LH, 32'h0000_2002, 32'h0, 5'd10, 0, 1, 32'h1234_F00D);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd) begin
            errors++;
            $display("FAIL lh_result: lv=%b data=%h rd=%0d, want %b %h %0d", obs_lv, obs_data, obs_rd, e.lv, e.data, e.rd);
        end
        sb.push_back('{lv: 1'b1, data: 32'h0000_8001, rd: 5'd11, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LHU, 32'h0000_2000, 32'h0, 5'd11, 0, 1, 32'h8001_7777);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd) begin
            errors++;
            $display("FAIL lhu_result: lv=%b data=%h rd=%0d, want %b %h %0d", obs_lv, obs_data, obs_rd, e.lv, e.data, e.rd);
        end
    endtask

    task automatic test_misalign();
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b1, berr: 1'b0});
        drive_op(LDST_SW, 32'h0000_3002, 32'h1111_2222, 5'd0, 0, 0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr} || obs_req_seen || obs_stall !== 1) begin
            errors++;
            $display("FAIL sw_misalign: lv/mis/berr=%b%b%b req_seen=%b stall=%0d, want 010 0 1",
                     obs_lv, obs_mis, obs_berr, obs_req_seen, obs_stall);
        end
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b1, berr: 1'b0});
        drive_op(LDST_LH, 32'h0000_2001, 32'h0, 5'd3, 0, 1, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr} || obs_req_seen) begin
            errors++;
            $display("FAIL lh_misalign: lv/mis/berr=%b%b%b req_seen=%b, want 010 0", obs_lv, obs_mis, obs_berr, obs_req_seen);
        end
    endtask

    task automatic test_store_half_hold();
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_SH, 32'h0000_4000, 32'h0000_BEEF, 5'd0, 5, 0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (!obs_stable || obs_we !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_addr !== 32'h0000_4000) begin
            errors++;
            $display("FAIL sh_hold: stable=%b we=%b wdata=%h addr=%h, want 1 1100 beefbeef 00004000",
                     obs_stable, obs_we, obs_wdata, obs_addr);
        end
        checks++;
        if (obs_stall !== 7 || {obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr}) begin
            errors++;
            $display("FAIL sh_done_timing: stall=%0d flags=%b%b%b, want 7 000", obs_stall, obs_lv, obs_mis, obs_berr);
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b0, berr: 1'b1});
        drive_op(LDST_LW, 32'h0000_5000, 32'h0, 5'd12, 0, -1, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr} || obs_stall !== 6) begin
            errors++;
            $display("FAIL lw_timeout: flags=%b%b%b stall=%0d, want 001 6", obs_lv, obs_mis, obs_berr, obs_stall);
        end
        // Late response while IDLE must be dropped
        dmem_resp_valid = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp: ld_valid=%b stall=%b bus_err=%b, want 0 0 0", ld_valid, stall, bus_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; ldst_ctrl = LDST_LW; addr = 32'h0000_6000; rd_in = 5'd7;
        @(posedge clk); #1;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait: stall=%b req=%b, want 1 0", stall, dmem_req_valid);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: stall=%b req=%b lv=%b berr=%b, want 0 0 0 0", stall, dmem_req_valid, ld_valid, bus_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{lv: 1'b1, data: 32'hCAFE_F00D, rd: 5'd7, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LW, 32'h0000_6000, 32'h0, 5'd7, 0, 1, 32'hCAFE_F00D);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd || obs_stall !== 3) begin
            errors++;
            $display("FAIL lw_after_reset: lv=%b data=%h rd=%0d stall=%0d, want %b %h %0d 3",
                     obs_lv, obs_data, obs_rd, obs_stall, e.lv, e.data, e.rd);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{lv: 1'b0, data: 32'h0, rd: 5'd0, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_SW, 32'h0000_7000, 32'h0102_0304, 5'd0, 0, 0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (obs_we !== 4'b1111 || obs_wdata !== 32'h0102_0304 || obs_stall !== 2 ||
            {obs_lv, obs_mis, obs_berr} !== {e.lv, e.mis, e.berr}) begin
            errors++;
            $display("FAIL b2b_sw: we=%b wdata=%h stall=%0d flags=%b%b%b, want 1111 01020304 2 000",
                     obs_we, obs_wdata, obs_stall, obs_lv, obs_mis, obs_berr);
        end
        sb.push_back('{lv: 1'b1, data: 32'hDEAD_BEEF, rd: 5'd9, mis: 1'b0, berr: 1'b0});
        drive_op(LDST_LW, 32'h0000_7004, 32'h0, 5'd9, 0, 2, 32'hDEAD_BEEF);
        e = sb.pop_front();
        checks++;
        if (obs_lv !== e.lv || obs_data !== e.data || obs_rd !== e.rd || obs_stall !== 4 || obs_addr !== 32'h0000_7004) begin
            errors++;
            $display("FAIL b2b_lw: lv=%b data=%h rd=%0d stall=%0d addr=%h, want %b %h %0d 4 00007004",
                     obs_lv, obs_data, obs_rd, obs_stall, obs_addr, e.lv, e.data, e.rd);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_misalign();
        test_store_half_hold();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
